// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing defaults and small helpers for the 640x480 @ 60 Hz sync path.
// The graphic generator imports the same package for its visible-area bounds.
package vga_sync_gen_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // Inclusive window test on a scan count.
  function automatic logic in_window(
    input logic [CNT_W-1:0] cnt,
    input int               lo,
    input int               hi
  );
    int value;
    value = int'(cnt);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate enable: one-clk pulse every CLK_DIV system clocks.
module vga_pixel_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic p_tick
);

  localparam int                DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1'b1);
  localparam logic [DIV_W-1:0]  DIV_ZERO = {DIV_W{1'b0}};

  logic [DIV_W-1:0] div_cnt;

  // Free-running divider counter, 0..CLK_DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= DIV_ZERO;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= DIV_ZERO;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  assign p_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480 VGA scan timing: pixel enable, scan counters, sync pulses and
// position/visibility outputs for the downstream graphic generator.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic             clk,
  input  logic             rst,
  output logic             p_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] CNT_ZERO  = 10'd0;
  localparam logic [CNT_W-1:0] CNT_ONE   = 10'd1;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             frame_wrap;
  logic             hsync_reg;
  logic             vsync_reg;
  logic             frame_start_reg;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick (
    .clk    (clk),
    .rst    (rst),
    .p_tick (p_tick)
  );

  // Next scan position; counters only move on a pixel tick.
  always_comb begin
    h_next     = h_cnt;
    v_next     = v_cnt;
    frame_wrap = 1'b0;
    if (p_tick) begin
      if (h_cnt == H_LAST) begin
        h_next = CNT_ZERO;
        if (v_cnt == V_LAST) begin
          v_next     = CNT_ZERO;
          frame_wrap = 1'b1;
        end else begin
          v_next = v_cnt + CNT_ONE;
        end
      end else begin
        h_next = h_cnt + CNT_ONE;
      end
    end else begin
      h_next = h_cnt;
      v_next = v_cnt;
    end
  end

  // Scan counters plus syncs decoded from the next position so that every
  // registered output changes on the same edge as the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt           <= CNT_ZERO;
      v_cnt           <= CNT_ZERO;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      frame_start_reg <= 1'b0;
    end else begin
      h_cnt           <= h_next;
      v_cnt           <= v_next;
      hsync_reg       <= ~in_window(h_next, HS_START, HS_END);
      vsync_reg       <= ~in_window(v_next, VS_START, VS_END);
      frame_start_reg <= frame_wrap;
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign frame_start = frame_start_reg;
  assign pixel_x     = h_cnt;
  assign pixel_y     = v_cnt;
  assign video_on    = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen; a short 6-line frame keeps full-frame runs cheap
// while the horizontal timing stays at the 640x480 defaults.
module tb_vga_sync_gen;

  localparam int CLK_DIV    = 4;
  localparam int H_DISPLAY  = 640;
  localparam int H_FRONT    = 16;
  localparam int H_SYNC     = 96;
  localparam int H_BACK     = 48;
  localparam int V_DISPLAY  = 2;
  localparam int V_FRONT    = 1;
  localparam int V_SYNC     = 2;
  localparam int V_BACK     = 1;
  localparam int H_TOTAL    = 800;
  localparam int V_TOTAL    = 6;
  localparam int LINE_CLKS  = CLK_DIV * H_TOTAL;
  localparam int FRAME_CLKS = LINE_CLKS * V_TOTAL;
  localparam int HS_LO = 656, HS_HI = 751;
  localparam int VS_LO = 3,   VS_HI = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       p_tick, hsync, vsync, video_on, frame_start;
  logic [9:0] pixel_x, pixel_y;

  int checks = 0;
  int errors = 0;
  int e      = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV(CLK_DIV), .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC),
    .H_BACK(H_BACK), .V_DISPLAY(V_DISPLAY), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC),
    .V_BACK(V_BACK)
  ) dut (
    .clk(clk), .rst(rst), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start)
  );

  wire logic [24:0] dut_vec = {pixel_x, pixel_y, hsync, vsync, video_on, p_tick, frame_start};

  // Expected outputs after the e-th rising edge since reset release.
  function automatic logic [24:0] model(input int n);
    int x, y;
    logic hs, vs, vid, tk, fs;
    x   = (n / CLK_DIV) % H_TOTAL;
    y   = (n / LINE_CLKS) % V_TOTAL;
    hs  = !(x >= HS_LO && x <= HS_HI);
    vs  = !(y >= VS_LO && y <= VS_HI);
    vid = (x < H_DISPLAY) && (y < V_DISPLAY);
    tk  = (n % CLK_DIV) == (CLK_DIV - 1);
    fs  = (n > 0) && ((n % FRAME_CLKS) == 0);
    return {x[9:0], y[9:0], hs, vs, vid, tk, fs};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) e++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (dut_vec !== model(0)) begin
        errors++;
        $display("FAIL reset_hold: got %h expected %h", dut_vec, model(0));
      end
    end
    rst = 1'b1;
    e   = 0;
    // p_tick is high in the cycle ending at the 4th edge; counters move on that edge.
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (p_tick !== (k == 3)) begin
        errors++;
        $display("FAIL first_tick edge %0d: got %b expected %b", k, p_tick, (k == 3));
      end
      checks++;
      if (pixel_x !== ((k == 4) ? 10'd1 : 10'd0)) begin
        errors++;
        $display("FAIL first_move edge %0d: got %0d expected %0d", k, pixel_x, (k == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_cadence();
    int n, last, bad;
    n = 0; last = -1; bad = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (p_tick) begin
        if (last >= 0 && (c - last) != 4) bad++;
        last = c;
        n++;
      end
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL tick_count: got %0d expected 10", n);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL tick_spacing: got %0d bad gaps expected 0", bad);
    end
  endtask

  task automatic test_hsync();
    int falls, rises;
    logic prev_hs;
    falls = 0; rises = 0; prev_hs = hsync;
    while (e < 3008) begin
      step();
      checks++;
      if (dut_vec !== model(e)) begin
        errors++;
        $display("FAIL hline e=%0d: got %h expected %h", e, dut_vec, model(e));
      end
      if (prev_hs && !hsync) falls++;
      if (!prev_hs && hsync) rises++;
      prev_hs = hsync;
      if (e == 2624 || e == 3008) begin
        checks++;
        if (pixel_x !== ((e == 2624) ? 10'd656 : 10'd752) || hsync !== (e == 3008)) begin
          errors++;
          $display("FAIL hsync_edge e=%0d: got x=%0d hs=%b", e, pixel_x, hsync);
        end
      end
      if (e == 2560) begin
        checks++;
        if (video_on !== 1'b0 || pixel_x !== 10'd640) begin
          errors++;
          $display("FAIL video_off: got x=%0d vid=%b expected x=640 vid=0", pixel_x, video_on);
        end
      end
    end
    checks++;
    if (falls !== 1 || rises !== 1) begin
      errors++;
      $display("FAIL hsync_pulses: got falls=%0d rises=%0d expected 1/1", falls, rises);
    end
  endtask

  task automatic test_wrap();
    int vs_ticks, y_min, y_max;
    vs_ticks = 0; y_min = 1023; y_max = -1;
    while (e < LINE_CLKS - 1) step();
    checks++;
    if (pixel_x !== 10'd799 || pixel_y !== 10'd0 || p_tick !== 1'b1) begin
      errors++;
      $display("FAIL line_end: got (%0d,%0d) tick=%b expected (799,0) tick=1", pixel_x, pixel_y, p_tick);
    end
    step();
    checks++;
    if (pixel_x !== 10'd0 || pixel_y !== 10'd1) begin
      errors++;
      $display("FAIL line_wrap: got (%0d,%0d) expected (0,1)", pixel_x, pixel_y);
    end
    while (e < FRAME_CLKS - 1) begin
      step();
      if (p_tick && !vsync) begin
        vs_ticks++;
        if (int'(pixel_y) < y_min) y_min = int'(pixel_y);
        if (int'(pixel_y) > y_max) y_max = int'(pixel_y);
      end
    end
    checks++;
    if (vs_ticks !== 1600 || y_min !== VS_LO || y_max !== VS_HI) begin
      errors++;
      $display("FAIL vsync_window: got %0d ticks lines %0d..%0d expected 1600 lines 3..4", vs_ticks, y_min, y_max);
    end
    checks++;
    if (pixel_x !== 10'd799 || pixel_y !== 10'd5 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: got (%0d,%0d) fs=%b expected (799,5) fs=0", pixel_x, pixel_y, frame_start);
    end
    step();
    checks++;
    if (pixel_x !== 10'd0 || pixel_y !== 10'd0 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_wrap: got (%0d,%0d) fs=%b expected (0,0) fs=1", pixel_x, pixel_y, frame_start);
    end
    step();
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL frame_start_width: got %b expected 0", frame_start);
    end
  endtask

  task automatic test_frame_period();
    int n;
    logic seen;
    n = 1; seen = 1'b0;
    while (!seen && n < FRAME_CLKS + 5000) begin
      step();
      n++;
      if (frame_start) seen = 1'b1;
    end
    checks++;
    if (!seen || n !== FRAME_CLKS) begin
      errors++;
      $display("FAIL frame_period: got %0d clocks (seen=%b) expected %0d", n, seen, FRAME_CLKS);
    end
  endtask

  task automatic test_async_reset();
    int target;
    target = 2 * FRAME_CLKS + VS_HI * LINE_CLKS + 700 * CLK_DIV;
    while (e < target) step();
    checks++;
    if (dut_vec !== model(e)) begin
      errors++;
      $display("FAIL pre_reset: got %h expected %h", dut_vec, model(e));
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (dut_vec !== model(0)) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", dut_vec, model(0));
    end
    @(negedge clk);
    rst = 1'b1;
    e   = 0;
    checks++;
    if (dut_vec !== model(0)) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", dut_vec, model(0));
    end
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (dut_vec !== model(e)) begin
        errors++;
        $display("FAIL restart e=%0d: got %h expected %h", e, dut_vec, model(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_hsync();
    test_wrap();
    test_frame_period();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
